mc_cu: RTL and testbench
========================

Name: mc_cu

Overview:
Multi-cycle control unit for the MIPS-subset CPU. It has the same ISA as the single-cycle control unit. It sequences one shared ALU and one shared instruction/data memory through the states IF, ID, EXE, MEM and WB. It sits beside the multi-cycle datapath and drives all of the datapath's write enables and mux selects from the current state, op, func and z. It stalls on a memory-ready handshake.

Parameters:
MEM_WAIT_EN, 1, 1 = honour mem_ready; 0 = mem_ready is internally treated as 1 (single-cycle memory).

Ports:
clock  in  1  system clock, rising edge
resetn  in  1  asynchronous, active-low reset
op  in  6  instruction opcode, valid from the ID state onward (IR output)
func  in  6  R-type function field
z  in  1  ALU zero flag, same cycle
mem_ready  in  1  memory access completes this cycle
state  out  3  current state: IF=0, ID=1, EXE=2, MEM=3, WB=4
wpc, wir, wmem, wreg  out  1 each  PC, IR, memory and register-file write enables
iord  out  1  memory address select: 0 = PC, 1 = ALUout
regrt  out  1  register destination select: 1 = rt, 0 = rd
m2reg  out  1  writeback select: 1 = MDR, 0 = ALUout
jal  out  1  register destination = $31, data = PC
shift  out  1  ALU operand A = sa field
alusrca  out  1  ALU operand A select: 0 = PC, 1 = register A
alusrcb  out  2  ALU operand B select: 00 = register B, 01 = constant 4, 10 = extended immediate, 11 = extended immediate << 2
sext  out  1  1 = sign-extend immediate, 0 = zero-extend
aluc  out  4  add=0000, sub=0100, and=0001, or=0101, xor=0010, lui=0110, sll=0011, srl=0111, sra=1111
pcsource  out  2  next-PC select: 00 = ALU, 01 = ALUout register, 10 = register A (jr), 11 = jump target
done  out  1  one-cycle pulse in the final cycle of every instruction
illegal  out  1  one-cycle pulse in ID when op/func is not supported

Behaviour:
- Supported ISA: add, sub, and, or, xor, sll, srl, sra, jr, addi, andi, ori, xori, lw, sw, beq, bne, lui, j, jal. The encodings are the standard MIPS ones.
- Reset: asynchronous on resetn low, forcing state = IF.
- While resetn = 0, wpc, wir, wmem, wreg, done and illegal are forced to 0.
- Only state is registered. All other outputs are combinational from state, op, func, z and mem_ready.
- Any output not listed for a state is 0.
- IF:
  - iord=0, alusrca=0, alusrcb=01, aluc=add, pcsource=00.
  - When mem_ready=1: wir=1, wpc=1, go to ID.
  - When mem_ready=0: stay in IF with wir=0 and wpc=0.
- ID (decode; branch target computed into ALUout):
  - alusrca=0, alusrcb=11, sext=1, aluc=add.
  - j: wpc=1, pcsource=11, done=1, go to IF.
  - jal: same as j, plus wreg=1 and jal=1. The return address is the already-incremented PC.
  - jr: wpc=1, pcsource=10, done=1, go to IF.
  - Unsupported op/func: illegal=1, done=1, go to IF; no state is written.
  - Anything else: go to EXE.
- EXE:
  - alusrca=1. shift=1 for sll/srl/sra.
  - alusrcb=00 for R-type and beq/bne; 10 for addi/andi/ori/xori/lui/lw/sw.
  - sext=1 for addi, lw, sw, beq, bne and lui; 0 for andi, ori and xori.
  - aluc per instruction: andi→and, ori→or, xori→xor, lw/sw/addi→add, beq/bne→sub.
  - beq/bne: aluc=sub, pcsource=01, wpc = (beq&z)|(bne&~z), done=1, go to IF.
  - lw/sw: go to MEM. All other instructions: go to WB.
- MEM: iord=1.
  - sw: wmem=1 held for every cycle until mem_ready. On mem_ready: done=1, go to IF.
  - lw: on mem_ready, go to WB.
  - Stay in MEM while mem_ready=0.
- WB:
  - wreg=1, done=1, go to IF.
  - regrt=1 for I-type; m2reg=1 for lw.
- Latency with zero wait states: j/jr/jal = 2 cycles, beq/bne = 3, R-type/I-type ALU = 4, sw = 4, lw = 5. Each cycle with mem_ready low adds 1 cycle.
- mem_ready is ignored outside IF and MEM.
- resetn asserted mid-instruction: partial instruction is abandoned, no write enable fires after the reset edge, and execution restarts in IF.
- Codes 5–7 on state are unreachable. If entered, the next state is IF with all outputs 0.

Test Plan:
- Reset, then add (op=000000, func=100000), mem_ready=1 always → state sequence 0,1,2,4,0. wir and wpc high in cycle 0. wreg=1 with regrt=0 and done=1 in cycle 3.
- lw (op=100011) with mem_ready low for 2 cycles in IF and 3 cycles in MEM → total 10 cycles. iord=1 throughout MEM, m2reg=1 and wreg=1 in WB, wmem never asserted.
- sw (op=101011), mem_ready low for 2 cycles in MEM → wmem=1 for 3 consecutive cycles, then return to IF; wreg stays 0.
- beq with z=1, then beq with z=0, then bne with z=0 → wpc=1 with pcsource=01 in EXE for the 1st and 3rd, wpc=0 for the 2nd; each instruction takes 3 cycles.
- jal (op=000011) → ID asserts wpc=1, pcsource=11, wreg=1, jal=1, done=1; 2-cycle instruction. Also op=111111 → illegal=1 and done=1 in ID, no write enable asserted, next state IF.
- resetn pulled low in the MEM state of an sw while wmem=1 → wmem drops immediately (asynchronously), state=0, first post-reset cycle fetches normally.

Source files
------------

// File: rtl/mc_cu.sv
// mc_cu - multi-cycle control unit for the MIPS-subset CPU.
//
// Sequences a shared ALU and a shared instruction/data memory through the
// IF, ID, EXE, MEM and WB states. Only the state is registered; every other
// output is decoded combinationally from the current state, op, func, z and
// mem_ready.
//
// Ports:
//   clock      in   system clock, rising edge
//   resetn     in   asynchronous active-low reset
//   op[5:0]    in   instruction opcode (valid from ID onward)
//   func[5:0]  in   R-type function field
//   z          in   ALU zero flag, same cycle
//   mem_ready  in   memory access completes this cycle
//   state[2:0] out  IF=0, ID=1, EXE=2, MEM=3, WB=4
//   wpc, wir, wmem, wreg  out  PC, IR, memory, register-file write enables
//   iord       out  memory address select (0 = PC, 1 = ALUout)
//   regrt      out  register destination select (1 = rt, 0 = rd)
//   m2reg      out  writeback select (1 = MDR, 0 = ALUout)
//   jal        out  destination = $31, data = PC
//   shift      out  ALU operand A = sa field
//   alusrca    out  ALU operand A select (0 = PC, 1 = register A)
//   alusrcb[1:0] out ALU operand B select (B, 4, imm, imm<<2)
//   sext       out  1 = sign-extend immediate
//   aluc[3:0]  out  ALU operation code
//   pcsource[1:0] out next-PC select (ALU, ALUout, A, jump target)
//   done       out  pulse in the final cycle of every instruction
//   illegal    out  pulse in ID for an unsupported op/func
//
// Parameter MEM_WAIT_EN: 1 honours mem_ready, 0 treats memory as always ready.

module mc_cu #(
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [5:0] op,
  input  logic [5:0] func,
  input  logic       z,
  input  logic       mem_ready,
  output logic [2:0] state,
  output logic       wpc,
  output logic       wir,
  output logic       wmem,
  output logic       wreg,
  output logic       iord,
  output logic       regrt,
  output logic       m2reg,
  output logic       jal,
  output logic       shift,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic       sext,
  output logic [3:0] aluc,
  output logic [1:0] pcsource,
  output logic       done,
  output logic       illegal
);

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EXE = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_SRA = 6'b000011;
  localparam logic [5:0] FN_JR  = 6'b001000;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0100;
  localparam logic [3:0] ALU_AND = 4'b0001;
  localparam logic [3:0] ALU_OR  = 4'b0101;
  localparam logic [3:0] ALU_XOR = 4'b0010;
  localparam logic [3:0] ALU_LUI = 4'b0110;
  localparam logic [3:0] ALU_SLL = 4'b0011;
  localparam logic [3:0] ALU_SRL = 4'b0111;
  localparam logic [3:0] ALU_SRA = 4'b1111;

  state_t state_q;
  state_t state_d;

  logic ready;

  logic r_type;
  logic is_add, is_sub, is_and, is_or, is_xor;
  logic is_sll, is_srl, is_sra, is_jr;
  logic is_addi, is_andi, is_ori, is_xori, is_lui;
  logic is_lw, is_sw, is_beq, is_bne, is_j, is_jal;
  logic is_shift, is_branch, supported, sext_imm;

  logic [3:0] exe_aluc;

  logic wpc_c, wir_c, wmem_c, wreg_c, done_c, illegal_c;

  // With waits disabled the memory is treated as completing every access
  // in the same cycle it is requested.
  assign ready = MEM_WAIT_EN ? mem_ready : 1'b1;

  // Instruction decode, shared by every state that needs to know the opcode.
  assign r_type  = (op == OP_RTYPE);
  assign is_add  = r_type && (func == FN_ADD);
  assign is_sub  = r_type && (func == FN_SUB);
  assign is_and  = r_type && (func == FN_AND);
  assign is_or   = r_type && (func == FN_OR);
  assign is_xor  = r_type && (func == FN_XOR);
  assign is_sll  = r_type && (func == FN_SLL);
  assign is_srl  = r_type && (func == FN_SRL);
  assign is_sra  = r_type && (func == FN_SRA);
  assign is_jr   = r_type && (func == FN_JR);
  assign is_addi = (op == OP_ADDI);
  assign is_andi = (op == OP_ANDI);
  assign is_ori  = (op == OP_ORI);
  assign is_xori = (op == OP_XORI);
  assign is_lui  = (op == OP_LUI);
  assign is_lw   = (op == OP_LW);
  assign is_sw   = (op == OP_SW);
  assign is_beq  = (op == OP_BEQ);
  assign is_bne  = (op == OP_BNE);
  assign is_j    = (op == OP_J);
  assign is_jal  = (op == OP_JAL);

  assign is_shift  = is_sll | is_srl | is_sra;
  assign is_branch = is_beq | is_bne;
  assign sext_imm  = is_addi | is_lw | is_sw | is_branch | is_lui;

  assign supported = is_add | is_sub | is_and | is_or | is_xor | is_shift |
                     is_jr | is_addi | is_andi | is_ori | is_xori | is_lui |
                     is_lw | is_sw | is_branch | is_j | is_jal;

  // ALU operation selected for the execute cycle; loads, stores and addi
  // fall through to add.
  always_comb begin
    exe_aluc = ALU_ADD;
    if (is_sub || is_branch)     exe_aluc = ALU_SUB;
    else if (is_and || is_andi)  exe_aluc = ALU_AND;
    else if (is_or  || is_ori)   exe_aluc = ALU_OR;
    else if (is_xor || is_xori)  exe_aluc = ALU_XOR;
    else if (is_lui)             exe_aluc = ALU_LUI;
    else if (is_sll)             exe_aluc = ALU_SLL;
    else if (is_srl)             exe_aluc = ALU_SRL;
    else if (is_sra)             exe_aluc = ALU_SRA;
  end

  // State register; reset abandons whatever instruction was in flight.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state_q <= S_IF;
    else         state_q <= state_d;
  end

  // Next-state and output decode. Everything starts at zero so each state
  // only names the controls it actually drives.
  always_comb begin
    state_d   = state_q;
    wpc_c     = 1'b0;
    wir_c     = 1'b0;
    wmem_c    = 1'b0;
    wreg_c    = 1'b0;
    done_c    = 1'b0;
    illegal_c = 1'b0;
    iord      = 1'b0;
    regrt     = 1'b0;
    m2reg     = 1'b0;
    jal       = 1'b0;
    shift     = 1'b0;
    alusrca   = 1'b0;
    alusrcb   = 2'b00;
    sext      = 1'b0;
    aluc      = ALU_ADD;
    pcsource  = 2'b00;

    case (state_q)
      S_IF: begin
        alusrcb = 2'b01;
        if (ready) begin
          wir_c   = 1'b1;
          wpc_c   = 1'b1;
          state_d = S_ID;
        end
      end

      S_ID: begin
        // The ALU precomputes the branch target into ALUout here.
        alusrcb = 2'b11;
        sext    = 1'b1;
        if (is_j || is_jal) begin
          wpc_c    = 1'b1;
          pcsource = 2'b11;
          done_c   = 1'b1;
          wreg_c   = is_jal;
          jal      = is_jal;
          state_d  = S_IF;
        end else if (is_jr) begin
          wpc_c    = 1'b1;
          pcsource = 2'b10;
          done_c   = 1'b1;
          state_d  = S_IF;
        end else if (!supported) begin
          illegal_c = 1'b1;
          done_c    = 1'b1;
          state_d   = S_IF;
        end else begin
          state_d = S_EXE;
        end
      end

      S_EXE: begin
        alusrca = 1'b1;
        shift   = is_shift;
        alusrcb = (r_type || is_branch) ? 2'b00 : 2'b10;
        sext    = sext_imm;
        aluc    = exe_aluc;
        if (is_branch) begin
          pcsource = 2'b01;
          wpc_c    = (is_beq & z) | (is_bne & ~z);
          done_c   = 1'b1;
          state_d  = S_IF;
        end else if (is_lw || is_sw) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end

      S_MEM: begin
        // A store keeps its write enable up until memory accepts it.
        iord = 1'b1;
        if (is_sw) begin
          wmem_c = 1'b1;
          if (ready) begin
            done_c  = 1'b1;
            state_d = S_IF;
          end
        end else if (ready) begin
          state_d = S_WB;
        end
      end

      S_WB: begin
        wreg_c  = 1'b1;
        done_c  = 1'b1;
        regrt   = ~r_type;
        m2reg   = is_lw;
        state_d = S_IF;
      end

      default: begin
        state_d = S_IF;
      end
    endcase
  end

  // Write enables and pulses are held off for as long as reset is asserted,
  // independent of the clock.
  assign wpc     = wpc_c     & resetn;
  assign wir     = wir_c     & resetn;
  assign wmem    = wmem_c    & resetn;
  assign wreg    = wreg_c    & resetn;
  assign done    = done_c    & resetn;
  assign illegal = illegal_c & resetn;

  assign state = state_q;

endmodule

// File: tb/tb_mc_cu.sv
// tb_mc_cu - self-checking bench for mc_cu.
//
// A table of whole-instruction vectors (latency and write-enable counts)
// is checked first, then per-cycle output vectors are compared against a
// reference model that expands each instruction into its expected cycles
// from the ISA timing rules, for directed and random instruction streams.
// A mid-store reset sequence is checked by hand.

module tb_mc_cu;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic [5:0] op = '0;
  logic [5:0] func = '0;
  logic       z = 1'b0;
  logic       mem_ready = 1'b0;
  logic [2:0] state;
  logic       wpc, wir, wmem, wreg, iord, regrt, m2reg, jal, shift, alusrca;
  logic [1:0] alusrcb;
  logic       sext;
  logic [3:0] aluc;
  logic [1:0] pcsource;
  logic       done, illegal;

  int errors = 0;
  int checks = 0;

  mc_cu #(.MEM_WAIT_EN(1'b1)) dut (
    .clock(clock), .resetn(resetn), .op(op), .func(func), .z(z),
    .mem_ready(mem_ready), .state(state), .wpc(wpc), .wir(wir),
    .wmem(wmem), .wreg(wreg), .iord(iord), .regrt(regrt), .m2reg(m2reg),
    .jal(jal), .shift(shift), .alusrca(alusrca), .alusrcb(alusrcb),
    .sext(sext), .aluc(aluc), .pcsource(pcsource), .done(done),
    .illegal(illegal)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [2:0] st;
    logic       wpc, wir, wmem, wreg, iord, regrt, m2reg, jal, shift, alusrca;
    logic [1:0] alusrcb;
    logic       sext;
    logic [3:0] aluc;
    logic [1:0] pcsource;
    logic       done, illegal;
  } outs_t;

  typedef struct {
    logic  mr;
    outs_t exp;
  } cyc_t;

  typedef struct {
    logic [5:0] op, func;
    logic       zz;
    int         if_w, mem_w;
    int         cycles, n_wpc, n_wreg, n_wmem, n_ill;
  } vec_t;

  localparam int K_RALU = 0, K_SHIFT = 1, K_JR = 2, K_J = 3, K_JAL = 4,
                 K_IALU = 5, K_LW = 6, K_SW = 7, K_BR = 8, K_ILL = 9;

  function automatic outs_t sample_outputs();
    outs_t o;
    o = '{st: state, wpc: wpc, wir: wir, wmem: wmem, wreg: wreg, iord: iord,
          regrt: regrt, m2reg: m2reg, jal: jal, shift: shift,
          alusrca: alusrca, alusrcb: alusrcb, sext: sext, aluc: aluc,
          pcsource: pcsource, done: done, illegal: illegal};
    return o;
  endfunction

  function automatic outs_t blank(input logic [2:0] st);
    outs_t o;
    o = '0;
    o.st = st;
    return o;
  endfunction

  task automatic applyStimulus(input logic mr, input logic zz);
    mem_ready = mr;
    z = zz;
  endtask

  task automatic checkOutput(input string name, input outs_t exp);
    outs_t act;
    act = sample_outputs();
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  // Reference model: expand one instruction into its expected cycles using
  // the ISA timing rules, then drive and compare cycle by cycle.
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f,
                           input logic zz, input int if_w, input int mem_w,
                           input string tag);
    cyc_t q[$];
    cyc_t c;
    outs_t e;
    int kind;
    logic [3:0] ex_aluc;
    logic ex_sext;
    kind = K_ILL;
    ex_aluc = 4'b0000;
    ex_sext = 1'b0;
    if (o == 6'b000000) begin
      case (f)
        6'b100000: begin kind = K_RALU;  ex_aluc = 4'b0000; end
        6'b100010: begin kind = K_RALU;  ex_aluc = 4'b0100; end
        6'b100100: begin kind = K_RALU;  ex_aluc = 4'b0001; end
        6'b100101: begin kind = K_RALU;  ex_aluc = 4'b0101; end
        6'b100110: begin kind = K_RALU;  ex_aluc = 4'b0010; end
        6'b000000: begin kind = K_SHIFT; ex_aluc = 4'b0011; end
        6'b000010: begin kind = K_SHIFT; ex_aluc = 4'b0111; end
        6'b000011: begin kind = K_SHIFT; ex_aluc = 4'b1111; end
        6'b001000: kind = K_JR;
        default:   kind = K_ILL;
      endcase
    end else begin
      case (o)
        6'b001000: begin kind = K_IALU; ex_aluc = 4'b0000; ex_sext = 1'b1; end
        6'b001100: begin kind = K_IALU; ex_aluc = 4'b0001; end
        6'b001101: begin kind = K_IALU; ex_aluc = 4'b0101; end
        6'b001110: begin kind = K_IALU; ex_aluc = 4'b0010; end
        6'b001111: begin kind = K_IALU; ex_aluc = 4'b0110; ex_sext = 1'b1; end
        6'b100011: begin kind = K_LW;   ex_sext = 1'b1; end
        6'b101011: begin kind = K_SW;   ex_sext = 1'b1; end
        6'b000100, 6'b000101: begin kind = K_BR; ex_aluc = 4'b0100; ex_sext = 1'b1; end
        6'b000010: kind = K_J;
        6'b000011: kind = K_JAL;
        default:   kind = K_ILL;
      endcase
    end

    for (int i = 0; i < if_w; i++) begin
      e = blank(3'd0); e.alusrcb = 2'b01;
      c.mr = 1'b0; c.exp = e; q.push_back(c);
    end
    e = blank(3'd0); e.alusrcb = 2'b01; e.wir = 1'b1; e.wpc = 1'b1;
    c.mr = 1'b1; c.exp = e; q.push_back(c);

    e = blank(3'd1); e.alusrcb = 2'b11; e.sext = 1'b1;
    case (kind)
      K_J:   begin e.wpc = 1'b1; e.pcsource = 2'b11; e.done = 1'b1; end
      K_JAL: begin e.wpc = 1'b1; e.pcsource = 2'b11; e.done = 1'b1;
                   e.wreg = 1'b1; e.jal = 1'b1; end
      K_JR:  begin e.wpc = 1'b1; e.pcsource = 2'b10; e.done = 1'b1; end
      K_ILL: begin e.illegal = 1'b1; e.done = 1'b1; end
      default: ;
    endcase
    c.mr = 1'($urandom_range(0, 1)); c.exp = e; q.push_back(c);

    if (!(kind inside {K_J, K_JAL, K_JR, K_ILL})) begin
      e = blank(3'd2); e.alusrca = 1'b1; e.aluc = ex_aluc; e.sext = ex_sext;
      e.shift = (kind == K_SHIFT);
      e.alusrcb = (kind inside {K_RALU, K_SHIFT, K_BR}) ? 2'b00 : 2'b10;
      if (kind == K_BR) begin
        e.pcsource = 2'b01;
        e.wpc = (o == 6'b000100) ? zz : ~zz;
        e.done = 1'b1;
      end
      c.mr = 1'($urandom_range(0, 1)); c.exp = e; q.push_back(c);

      if (kind == K_LW || kind == K_SW) begin
        for (int i = 0; i < mem_w; i++) begin
          e = blank(3'd3); e.iord = 1'b1; e.wmem = (kind == K_SW);
          c.mr = 1'b0; c.exp = e; q.push_back(c);
        end
        e = blank(3'd3); e.iord = 1'b1; e.wmem = (kind == K_SW);
        e.done = (kind == K_SW);
        c.mr = 1'b1; c.exp = e; q.push_back(c);
      end

      if (kind != K_SW && kind != K_BR) begin
        e = blank(3'd4); e.wreg = 1'b1; e.done = 1'b1;
        e.regrt = !(kind inside {K_RALU, K_SHIFT});
        e.m2reg = (kind == K_LW);
        c.mr = 1'($urandom_range(0, 1)); c.exp = e; q.push_back(c);
      end
    end

    op = o;
    func = f;
    for (int i = 0; i < q.size(); i++) begin
      applyStimulus(q[i].mr, zz);
      @(negedge clock);
      checkOutput($sformatf("%s cyc%0d", tag, i), q[i].exp);
      @(posedge clock);
      #1;
    end
  endtask

  // Table runner: count cycles and enables until done, bounded by a budget.
  task automatic run_vector(input vec_t v, input int idx);
    int cyc, mem_cnt, n_wpc, n_wreg, n_wmem, n_ill;
    logic seen_done;
    logic mr;
    cyc = 0; mem_cnt = 0; n_wpc = 0; n_wreg = 0; n_wmem = 0; n_ill = 0;
    seen_done = 1'b0;
    op = v.op;
    func = v.func;
    while (!seen_done && cyc < 40) begin
      if (cyc < v.if_w) mr = 1'b0;
      else if (state == 3'd3 && mem_cnt < v.mem_w) begin
        mr = 1'b0;
        mem_cnt++;
      end else mr = 1'b1;
      applyStimulus(mr, v.zz);
      @(negedge clock);
      n_wpc += int'(wpc);
      n_wreg += int'(wreg);
      n_wmem += int'(wmem);
      n_ill += int'(illegal);
      seen_done = done;
      cyc++;
      @(posedge clock);
      #1;
    end
    check_int($sformatf("vec%0d cycles", idx), cyc, v.cycles);
    check_int($sformatf("vec%0d wpc", idx), n_wpc, v.n_wpc);
    check_int($sformatf("vec%0d wreg", idx), n_wreg, v.n_wreg);
    check_int($sformatf("vec%0d wmem", idx), n_wmem, v.n_wmem);
    check_int($sformatf("vec%0d illegal", idx), n_ill, v.n_ill);
    check_int($sformatf("vec%0d next state", idx), int'(state), 0);
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t tbl[$];
    outs_t e;
    logic [11:0] legal [20];
    logic [5:0] r_op, r_func;
    int idx;

    //           op         func       z   ifw memw cyc wpc wreg wmem ill
    tbl.push_back('{6'b000000, 6'b100000, 1'b0, 0, 0, 4,  1, 1, 0, 0});
    tbl.push_back('{6'b100011, 6'b000000, 1'b0, 2, 3, 10, 1, 1, 0, 0});
    tbl.push_back('{6'b101011, 6'b000000, 1'b0, 0, 2, 6,  1, 0, 3, 0});
    tbl.push_back('{6'b000100, 6'b000000, 1'b1, 0, 0, 3,  2, 0, 0, 0});
    tbl.push_back('{6'b000100, 6'b000000, 1'b0, 0, 0, 3,  1, 0, 0, 0});
    tbl.push_back('{6'b000101, 6'b000000, 1'b0, 0, 0, 3,  2, 0, 0, 0});
    tbl.push_back('{6'b000101, 6'b000000, 1'b1, 0, 0, 3,  1, 0, 0, 0});
    tbl.push_back('{6'b000011, 6'b000000, 1'b0, 0, 0, 2,  2, 1, 0, 0});
    tbl.push_back('{6'b000010, 6'b000000, 1'b0, 1, 0, 3,  2, 0, 0, 0});
    tbl.push_back('{6'b000000, 6'b001000, 1'b0, 0, 0, 2,  2, 0, 0, 0});
    tbl.push_back('{6'b111111, 6'b000000, 1'b0, 0, 0, 2,  1, 0, 0, 1});
    tbl.push_back('{6'b000000, 6'b000000, 1'b0, 0, 0, 4,  1, 1, 0, 0});
    tbl.push_back('{6'b001111, 6'b000000, 1'b0, 0, 0, 4,  1, 1, 0, 0});
    tbl.push_back('{6'b001100, 6'b000000, 1'b0, 1, 0, 5,  1, 1, 0, 0});
    tbl.push_back('{6'b000000, 6'b111111, 1'b0, 0, 0, 2,  1, 0, 0, 1});
    tbl.push_back('{6'b101011, 6'b000000, 1'b0, 0, 0, 4,  1, 0, 1, 0});

    legal = '{ {6'b000000, 6'b100000}, {6'b000000, 6'b100010},
               {6'b000000, 6'b100100}, {6'b000000, 6'b100101},
               {6'b000000, 6'b100110}, {6'b000000, 6'b000000},
               {6'b000000, 6'b000010}, {6'b000000, 6'b000011},
               {6'b000000, 6'b001000}, {6'b001000, 6'b000000},
               {6'b001100, 6'b000000}, {6'b001101, 6'b000000},
               {6'b001110, 6'b000000}, {6'b100011, 6'b000000},
               {6'b101011, 6'b000000}, {6'b000100, 6'b000000},
               {6'b000101, 6'b000000}, {6'b001111, 6'b000000},
               {6'b000010, 6'b000000}, {6'b000011, 6'b000000} };

    // Reset state: fetch controls visible, write enables held low even
    // though memory reports ready.
    applyStimulus(1'b1, 1'b0);
    #2;
    e = blank(3'd0); e.alusrcb = 2'b01;
    checkOutput("reset outputs", e);
    @(posedge clock);
    #1;
    resetn = 1'b1;

    for (int i = 0; i < tbl.size(); i++) run_vector(tbl[i], i);

    run_instr(6'b000000, 6'b100000, 1'b0, 0, 0, "add");
    run_instr(6'b100011, 6'b000000, 1'b0, 2, 3, "lw");
    run_instr(6'b101011, 6'b000000, 1'b0, 0, 2, "sw");
    run_instr(6'b000100, 6'b000000, 1'b1, 0, 0, "beq z1");
    run_instr(6'b000100, 6'b000000, 1'b0, 0, 0, "beq z0");
    run_instr(6'b000101, 6'b000000, 1'b0, 0, 0, "bne z0");
    run_instr(6'b000011, 6'b000000, 1'b0, 0, 0, "jal");
    run_instr(6'b111111, 6'b000000, 1'b0, 0, 0, "illegal op");

    for (int n = 0; n < 150; n++) begin
      idx = $urandom_range(0, 21);
      if (idx >= 20) begin
        r_op = 6'($urandom);
        r_func = 6'($urandom);
      end else begin
        r_op = legal[idx][11:6];
        r_func = (r_op == 6'b000000) ? legal[idx][5:0] : 6'($urandom);
      end
      run_instr(r_op, r_func, 1'($urandom_range(0, 1)),
                $urandom_range(0, 2), $urandom_range(0, 2),
                $sformatf("rand%0d op=%b func=%b", n, r_op, r_func));
    end

    // Reset in the middle of a stalled store.
    op = 6'b101011;
    func = 6'b000000;
    applyStimulus(1'b1, 1'b0);
    @(posedge clock); #1;
    @(posedge clock); #1;
    applyStimulus(1'b0, 1'b0);
    @(posedge clock); #1;
    @(negedge clock);
    e = blank(3'd3); e.iord = 1'b1; e.wmem = 1'b1;
    checkOutput("sw stalled before reset", e);
    #2;
    resetn = 1'b0;
    mem_ready = 1'b1;
    #1;
    e = blank(3'd0); e.alusrcb = 2'b01;
    checkOutput("async reset mid sw", e);
    @(posedge clock);
    #1;
    checkOutput("held in reset over edge", e);
    resetn = 1'b1;
    @(negedge clock);
    e = blank(3'd0); e.alusrcb = 2'b01; e.wir = 1'b1; e.wpc = 1'b1;
    checkOutput("fetch after reset", e);
    @(posedge clock);
    #1;
    e = blank(3'd1); e.alusrcb = 2'b11; e.sext = 1'b1;
    checkOutput("decode after reset", e);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
